// File: rtl/slidevm_pkg.sv
// Shared types and helpers for the multi-channel sliding-window SVM slice.
package slidevm_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of the per-entry window row index; at least one bit.
  function automatic int unsigned row_width(input int unsigned winrows);
    return $clog2(winrows > 2 ? winrows : 2);
  endfunction

  function automatic logic signed [64:0] wide_sum(input logic signed [63:0] a,
                                                  input logic signed [63:0] b);
    return 65'(a) + 65'(b);
  endfunction

  function automatic logic signed [64:0] sat_max(input int unsigned aw);
    return (65'sd1 <<< (aw - 1)) - 65'sd1;
  endfunction

  // Saturating add to an aw-bit signed range; operands already sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned aw);
    logic signed [64:0] s, hi, lo;
    s  = wide_sum(a, b);
    hi = sat_max(aw);
    lo = -hi - 65'sd1;
    if (s > hi) return hi[63:0];
    if (s < lo) return lo[63:0];
    return s[63:0];
  endfunction

  // True when sat_add with the same operands clamps.
  function automatic logic sat_ovf(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int unsigned aw);
    logic signed [64:0] s, hi;
    s  = wide_sum(a, b);
    hi = sat_max(aw);
    return (s > hi) || (s < (-hi - 65'sd1));
  endfunction

endpackage

// File: rtl/slice_mem_mc_if.sv
// Stream, configuration and result bundle of the multi-channel window accumulator.
interface slice_mem_mc_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CWIDTH = 9,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned NCH    = 4
);
  logic                   dvi;
  logic [DWIDTH-1:0]      data;
  logic                   newblock;
  logic                   download;
  logic [NCH*CWIDTH-1:0]  coeff;
  logic [NCH*AWIDTH-1:0]  bias;
  logic                   ready;
  logic                   score_valid;
  logic [NCH*AWIDTH-1:0]  score;
  logic [NCH-1:0]         msb;
  logic [NCH-1:0]         ovf;

  modport master (
    output dvi, data, newblock, download, coeff, bias,
    input  ready, score_valid, score, msb, ovf
  );

  modport slave (
    input  dvi, data, newblock, download, coeff, bias,
    output ready, score_valid, score, msb, ovf
  );
endinterface

// File: rtl/slice_line_fifo.sv
// Circular line store of partial window sums; one address serves read then write.
module slice_line_fifo #(
  parameter int unsigned DEPTH = 40,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         restart,
  input  logic         clr,
  input  logic         adv,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         last
);
  localparam int unsigned PTRW = $clog2(DEPTH > 2 ? DEPTH : 2);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] ptr;

  assign rdata = mem[ptr];
  assign last  = (ptr == PTRW'(DEPTH - 1));

  // Pointer walks the line once per zero-fill or fold, wrapping at the end.
  always_ff @(posedge clk) begin
    if (restart)          ptr <= '0;
    else if (clr || adv)  ptr <= last ? '0 : ptr + 1'b1;
  end

  // Zero-fill during initialisation, otherwise overwrite the entry just read.
  always_ff @(posedge clk) begin
    if (!restart && (clr || adv)) mem[ptr] <= clr ? '0 : wdata;
  end
endmodule

// File: rtl/slice_mem_mc.sv
// Multi-channel sliding-window SVM accumulator: shared data stream, NCH coefficient
// streams, per-row segment sums folded through a line FIFO into window scores.
module slice_mem_mc
  import slidevm_pkg::*;
#(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned CWIDTH  = 9,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned NCH     = 4,
  parameter int unsigned WINCOLS = 8,
  parameter int unsigned WINROWS = 16,
  parameter int unsigned WPI     = 40
) (
  input logic           clk,
  input logic           reset,
  slice_mem_mc_if.slave bus
);
  localparam int unsigned PW = DWIDTH + CWIDTH + 1;
  localparam int unsigned RW = row_width(WINROWS);
  localparam int unsigned BW = $clog2(WINCOLS > 2 ? WINCOLS : 2);
  localparam int unsigned FW = NCH * AWIDTH + RW;

  state_t          state, state_nx;
  logic            restart, ready_w, accept;
  logic            fifo_clr, fifo_adv, fifo_last;
  logic [BW-1:0]   blkcnt;
  logic            s1_valid, s1_seg_end;
  logic [FW-1:0]   head, push;
  logic [RW-1:0]   head_row;
  logic            last_row;
  logic            score_valid_q;

  assign restart  = reset | bus.download;
  assign ready_w  = (state == RUN);
  assign accept   = bus.dvi & ready_w;
  assign fifo_adv = s1_valid & s1_seg_end;
  assign head_row = head[RW-1:0];
  assign last_row = (head_row == RW'(WINROWS - 1));
  assign push[RW-1:0] = last_row ? '0 : head_row + 1'b1;

  assign bus.ready       = ready_w;
  assign bus.score_valid = score_valid_q;

  // State register; reset and download both force re-initialisation.
  always_ff @(posedge clk) begin
    if (restart) state <= INIT;
    else         state <= state_nx;
  end

  // INIT zero-fills one FIFO entry per cycle and leaves after the last one.
  always_comb begin
    state_nx = state;
    fifo_clr = 1'b0;
    case (state)
      INIT: begin
        fifo_clr = 1'b1;
        if (fifo_last) state_nx = RUN;
      end
      RUN: state_nx = RUN;
    endcase
  end

  // Block counter and stage-1 control flags travelling with the products.
  always_ff @(posedge clk) begin
    if (restart) begin
      s1_valid   <= 1'b0;
      s1_seg_end <= 1'b0;
      blkcnt     <= '0;
    end else begin
      s1_valid   <= accept;
      s1_seg_end <= accept & bus.newblock & (blkcnt == BW'(WINCOLS - 1));
      if (accept && bus.newblock)
        blkcnt <= (blkcnt == BW'(WINCOLS - 1)) ? '0 : blkcnt + 1'b1;
    end
  end

  // Window-complete strobe, aligned with the registered scores.
  always_ff @(posedge clk) begin
    if (restart) score_valid_q <= 1'b0;
    else         score_valid_q <= fifo_adv & last_row;
  end

  slice_line_fifo #(
    .DEPTH (WPI),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .restart (restart),
    .clr     (fifo_clr),
    .adv     (fifo_adv),
    .wdata   (push),
    .rdata   (head),
    .last    (fifo_last)
  );

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [CWIDTH-1:0] cf;
    logic signed [DWIDTH:0]   dext;
    logic signed [PW-1:0]     prod;
    logic signed [AWIDTH-1:0] acc, part, bias_c, seg, tot, fin, score_q;
    logic                     seg_hit, tot_hit, fin_hit, msb_q, ovf_q;

    assign cf     = bus.coeff[c*CWIDTH +: CWIDTH];
    assign dext   = {1'b0, bus.data};
    assign bias_c = bus.bias[c*AWIDTH +: AWIDTH];
    assign part   = head[RW + c*AWIDTH +: AWIDTH];

    assign seg     = AWIDTH'(sat_add(64'(acc), 64'(prod), AWIDTH));
    assign seg_hit = sat_ovf(64'(acc), 64'(prod), AWIDTH);
    assign tot     = AWIDTH'(sat_add(64'(part), 64'(seg), AWIDTH));
    assign tot_hit = sat_ovf(64'(part), 64'(seg), AWIDTH);
    assign fin     = AWIDTH'(sat_add(64'(tot), 64'(bias_c), AWIDTH));
    assign fin_hit = sat_ovf(64'(tot), 64'(bias_c), AWIDTH);

    assign push[RW + c*AWIDTH +: AWIDTH] = last_row ? '0 : tot;
    assign bus.score[c*AWIDTH +: AWIDTH] = score_q;
    assign bus.msb[c] = msb_q;
    assign bus.ovf[c] = ovf_q;

    // Stage 1: unsigned sample times signed coefficient.
    always_ff @(posedge clk) begin
      if (accept) prod <= PW'(dext) * PW'(cf);
    end

    // Stage 2: accumulate the segment, or fold it into the line entry and maybe emit.
    always_ff @(posedge clk) begin
      if (restart) begin
        acc     <= '0;
        score_q <= '0;
        msb_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (s1_valid) begin
        if (s1_seg_end) begin
          acc   <= '0;
          ovf_q <= ovf_q | seg_hit | tot_hit | (last_row & fin_hit);
          if (last_row) begin
            score_q <= fin;
            msb_q   <= ~fin[AWIDTH-1] & (|fin);
          end
        end else begin
          acc   <= seg;
          ovf_q <= ovf_q | seg_hit;
        end
      end
    end
  end
endmodule

// File: doc/slice_mem_mc.md
Name: slice_mem_mc

Overview:
Multi-channel successor to the single-slice sliding-window SVM accumulator in the slidevm process.
- One shared pixel/feature stream is multiplied by NCH independent support-vector coefficient streams.
- Each channel accumulates per-window-row segments and folds them, through a WPI-deep line FIFO, into full WINCOLS x WINROWS window scores.
- Each channel adds its bias, then emits a signed score, a decision bit and a saturation flag.

Parameters:
DWIDTH, 8, data width; data is unsigned.
CWIDTH, 9, per-channel coefficient width; signed.
AWIDTH, 32, accumulator, score and bias width; signed, saturating.
NCH, 4, number of parallel channels.
WINCOLS, 8, blocks per window row segment; must be >=1.
WINROWS, 16, segments (rows) per window; must be >=1.
WPI, 40, window positions per image line, i.e. FIFO depth; must be >=1.

Ports:
clk  in  1  clock; the only clock.
reset  in  1  synchronous reset, active-high.
dvi  in  1  data valid; qualifies data, newblock and coeff.
data  in  DWIDTH  feature sample.
newblock  in  1  marks the last sample of a block.
download  in  1  synchronous flush and reinitialisation request.
coeff  in  NCH*CWIDTH  per-channel coefficients; channel c occupies bits [c*CWIDTH +: CWIDTH].
bias  in  NCH*AWIDTH  per-channel bias, sampled when a score is emitted.
ready  out  1  high in RUN; dvi is ignored while ready is low.
score_valid  out  1  one-cycle strobe; a completed window score is on score.
score  out  NCH*AWIDTH  window sum plus bias, saturated.
msb  out  NCH  decision bit per channel: score[c] > 0.
ovf  out  NCH  sticky per channel; set on any saturation; cleared by reset or download.

Behaviour:
- FSM states: INIT, RUN.
  - reset or download moves the FSM to INIT from any state.
  - In INIT, FIFO entries 0..WPI-1 are written to zero, one per cycle. After WPI cycles the FSM enters RUN.
  - ready = (state == RUN).
- Reset values: ready 0, score_valid 0, score 0, msb 0, ovf 0. Block counter, accumulators, pipeline valids and FIFO pointer are all 0.
- Accepted sample: dvi & ready.
- Stage 1 (registered): p[c] = zero-extended data * coeff[c], width DWIDTH+CWIDTH+1 signed. Stage-1 valid, last_blk and seg_end flags travel with the product.
  - seg_end = newblock & (blkcnt == WINCOLS-1).
- Block counter: on an accepted sample with newblock, blkcnt increments and wraps from WINCOLS-1 to 0.
- Stage 2, on a stage-1 valid:
  - seg = acc[c] + p[c], saturated to AWIDTH.
  - If not seg_end: acc[c] <= seg.
  - If seg_end: acc[c] <= 0, and the FIFO head {part[c], row} is popped.
    - tot[c] = sat(part[c] + seg).
    - If row == WINROWS-1: push {0, 0}; register score[c] = sat(tot[c] + bias[c]) and msb[c]; pulse score_valid in the next cycle.
    - Otherwise: push {tot, row+1}.
- Latency: score_valid is high exactly 2 cycles after the accepted sample that closes the final segment. Idle cycles between samples do not affect results.
- FIFO:
  - Circular, WPI entries, one pop and one push per seg_end.
  - Pop and push use the same address (read-before-write); the pointer wraps from WPI-1 to 0.
  - The row index is stored per entry, so every window column position progresses independently.
- Saturation: clamp to [-2^(AWIDTH-1), 2^(AWIDTH-1)-1] at each addition; any clamp sets ovf[c].
- download or reset mid-window:
  - Abort immediately and discard in-flight pipeline samples; no score_valid is emitted.
  - Partial sums, counters and ovf are lost; the FIFO is re-zeroed in INIT.
- WINCOLS=1: every newblock is a seg_end. WPI=1: the single FIFO entry is reused by every segment.
- Samples offered during INIT are dropped without side effects.

Decomposition:
- Package slidevm_pkg holds:
  - the state enum {INIT, RUN};
  - a saturating-add function parametrised on AWIDTH;
  - the row-index width localparam, clog2(max(WINROWS,2)).
- Sub-module slice_line_fifo: single-port-address circular RAM of WPI x (NCH*AWIDTH + row width) with read-before-write, pointer advance, and a zero-fill write port driven by INIT.
- The top level holds the FSM, block counter, multipliers and per-channel accumulate/fold logic, generated over NCH.

Test Plan:
- Reset release, WPI=40 -> ready low for exactly 40 cycles, then high. All outputs 0 throughout INIT.
- NCH=2, WINCOLS=2, WINROWS=2, WPI=1, coeff={3,-2}, bias 0; data 1,2,3,4, each with newblock, back-to-back -> single score_valid 2 cycles after data 4; score={30,-20}, msb={1,0}.
- Same stimulus with bias={-40,25} and 3 idle cycles inserted between samples -> score={-10,5}, msb={0,1}; timing relative to the last sample is unchanged.
- AWIDTH=12, coeff 255, data 255 repeated, WINCOLS=4 -> score saturates at 2047; ovf[c] set and stays set until download.
- WPI=3, WINCOLS=1, WINROWS=2 -> six segments produce three scores, one per column position, in order, each equal to its own column's two segments summed.
- download asserted mid-window, then the full window replayed -> no spurious score_valid; ready low for WPI cycles; final score identical to a run from fresh reset.
